icache: RTL and testbench
=========================

# icache

Direct-mapped, read-only instruction cache for one CPU. It sits between the datapath instruction fetch port and one CPU slot of `memory_control`. Hits return `imemload` combinationally from a tag/data array. Misses raise `iREN` to the memory controller until `iwait` drops, then fill the frame. The block also keeps 32-bit hit/miss counters for the halt dump.

## Interface
Parameters:
- `SETS`, 16: number of frames, power of two, 2..256.
- `IIDX_W`, $clog2(SETS): index width.

Ports:
- `CLK`  in  1  clock; all state updates on posedge.
- `nRST`  in  1  asynchronous, active-low reset.
- `imemREN`  in  1  datapath fetch request.
- `imemaddr`  in  32  datapath byte address; bits [1:0] ignored.
- `ihit`  out  1  `imemload` valid this cycle.
- `imemload`  out  32  instruction word.
- `iREN`  out  1  read request to memory controller.
- `iaddr`  out  32  word-aligned fill address.
- `iwait`  in  1  memory controller stall; fill data valid when low while `iREN` high.
- `iload`  in  32  fill data.
- `iflush`  in  1  one-cycle pulse; invalidates all frames.
- `hitcnt`  out  32  saturating hit count.
- `misscnt`  out  32  saturating miss count.

## Operation
- Address split: offset [1:0]; index [IIDX_W+1:2]; tag [31:IIDX_W+2], with width TAG_W = 30-IIDX_W.
- Frame contents: valid (1), tag (TAG_W), data (32).
- FSM states:
  - IDLE: lookup; hit = `imemREN` & frame[idx].valid & tag match.
    - On hit: `ihit`=1, `imemload`=frame data, `hitcnt`++.
    - On miss: latch `{tag,idx}` into `missaddr`, `misscnt`++, go to FETCH.
  - FETCH: `iREN`=1, `iaddr`={missaddr,2'b00}, `ihit`=0.
    - Stay while `iwait`=1.
    - On `iwait`=0: write frame[missaddr.idx] = {1, tag, `iload`}, go to IDLE.
- A fill always completes to the latched address, even if `imemaddr` or `imemREN` changed meanwhile. There is no forwarding; the hit is reported by the IDLE lookup on the next cycle.
- `iflush` clears all valid bits next edge in any state.
  - In FETCH, the in-progress fill still writes its frame, valid=1: the fetched word is coherent since the icache is read-only.
  - Flush and fill writing the same frame in one cycle: fill wins.
- Counters saturate at 32'hFFFF_FFFF. Reset clears them; flush does not.
- `imemREN`=0 in IDLE: no lookup, no counting, `ihit`=0.

## Timing
- Reset (async, immediate):
  - state=IDLE, all valid=0, `missaddr`=0.
  - `iREN`=0, `iaddr`=0, `ihit`=0, `imemload`=0, `hitcnt`=0, `misscnt`=0.
- Reset mid-FETCH drops `iREN` immediately and discards the fill.
- Outputs:
  - `ihit` and `imemload` are combinational from the array in IDLE. `imemload`=0 when `ihit`=0.
  - `iREN` and `iaddr` are Moore outputs of FETCH.
- Hit latency: 0 cycles.
- Miss latency: 1 (detect) + N (cycles with `iwait`=1) + 1 (fill edge) + hit cycle. With `iwait` low on the first FETCH cycle, `ihit` rises 2 cycles after the miss cycle.
- Handshake: `iREN` stays high and `iaddr` stays stable from FETCH entry until the cycle `iwait` is sampled low. `iREN` is low the following cycle.
- Back-to-back misses: one IDLE cycle always separates consecutive FETCH episodes.
- `SETS` wrap: index aliasing replaces the frame; no other eviction state.

## Structure
- `cpu_types_pkg` gains:
  - `ITAG_W`, `IIDX_W` defaults.
  - `icachef_t` packed struct {tag, idx, bytoff}.
  - `icache_frame_t` {valid, tag, data}.
  - `icache_state_t` enum {IDLE, FETCH}.
- `word_t` is reused for data ports.
- One natural sub-module: `sat_counter` (32-bit, inc, clear-on-reset, saturating), instantiated twice.
- The frame array is plain registers, not a RAM macro.

## Test plan
- Cold miss:
  - Stimulus: `imemREN`=1, `imemaddr`=32'h0000_0040, `iwait` low after 3 cycles with `iload`=32'h2001_0005.
  - Required: `iREN` high 4 cycles with `iaddr`=32'h40, then `ihit`=1 with `imemload`=32'h2001_0005; `misscnt`=1, `hitcnt`=1.
- Repeat hit: same address held 5 more cycles → `ihit`=1 every cycle, `iREN`=0, `hitcnt`=6.
- Conflict eviction:
  - Stimulus: fetch 32'h40, then 32'h80 (same index at SETS=16, different tag), then 32'h40 again.
  - Required: three misses, `misscnt`=3; each returns its own `iload` value.
- Address change mid-fill:
  - Stimulus: miss on 32'h100, switch `imemaddr` to 32'h104 during FETCH.
  - Required: `iaddr` stays 32'h100, frame 0 filled; next IDLE misses on 32'h104 and fetches it.
- Flush:
  - Stimulus: fill 32'h40, pulse `iflush`, refetch 32'h40.
  - Required: miss again, counters not cleared.
  - Variant: flush during FETCH → fill still valid, next access hits.
- Reset mid-FETCH:
  - Stimulus: drop `nRST` while `iREN`=1.
  - Required: `iREN`=0 same cycle; after release, 32'h40 misses, both counters 0 before the access.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// ----------------------------------------------------------------------------
// cpu_types_pkg
//   Shared CPU types. The instruction-cache section describes the default
//   geometry (16 frames) and the address/frame layouts used by the icache.
//   word_t is the common 32-bit data type for all memory-side ports.
// ----------------------------------------------------------------------------
package cpu_types_pkg;

  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;

  // Default instruction-cache geometry: 16 direct-mapped frames.
  localparam int IIDX_W = 4;
  localparam int IBYT_W = 2;
  localparam int ITAG_W = WORD_W - IIDX_W - IBYT_W;

  // Fetch address split into tag / frame index / byte offset.
  typedef struct packed {
    logic [ITAG_W-1:0] tag;
    logic [IIDX_W-1:0] idx;
    logic [IBYT_W-1:0] bytoff;
  } icachef_t;

  // One cache frame.
  typedef struct packed {
    logic              valid;
    logic [ITAG_W-1:0] tag;
    word_t             data;
  } icache_frame_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

endpackage

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
//   32-bit event counter that sticks at all-ones instead of wrapping.
//   Cleared only by reset.
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset, clears the count
//   inc_i    in   count one event this cycle
//   count_o  out  current count
// ----------------------------------------------------------------------------
module sat_counter
  import cpu_types_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  inc_i,
  output word_t count_o
);

  word_t count_q;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values; blocking = here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + word_t'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/icache.sv
// ----------------------------------------------------------------------------
// icache
//   Direct-mapped, read-only instruction cache between the datapath fetch
//   port and one CPU slot of the memory controller. Hits are answered
//   combinationally from the frame array; a miss latches the word address,
//   holds iREN until iwait drops, then writes the frame and returns to IDLE,
//   where the next lookup reports the hit.
// Ports:
//   CLK        in   clock
//   nRST       in   asynchronous active-low reset
//   imemREN    in   datapath fetch request
//   imemaddr   in   datapath byte address (bits [1:0] ignored)
//   ihit       out  imemload valid this cycle
//   imemload   out  instruction word (0 when ihit is low)
//   iREN       out  fill request to memory controller
//   iaddr      out  word-aligned fill address
//   iwait      in   memory controller stall; fill data valid when low
//   iload      in   fill data
//   iflush     in   invalidate every frame at the next edge
//   hitcnt     out  saturating hit count
//   misscnt    out  saturating miss count
// ----------------------------------------------------------------------------
module icache
  import cpu_types_pkg::*;
#(
  parameter int SETS   = 16,
  parameter int IIDX_W = $clog2(SETS)
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  imemREN,
  input  word_t imemaddr,
  output logic  ihit,
  output word_t imemload,
  output logic  iREN,
  output word_t iaddr,
  input  logic  iwait,
  input  word_t iload,
  input  logic  iflush,
  output word_t hitcnt,
  output word_t misscnt
);

  localparam int TAG_W = 30 - IIDX_W;

  icache_state_t state_q, state_d;
  logic [29:0]   missaddr_q, missaddr_d;   // {tag, idx} of the pending fill

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  word_t            data_q [SETS];

  logic [TAG_W-1:0]  req_tag;
  logic [IIDX_W-1:0] req_idx;
  logic [IIDX_W-1:0] fill_idx;
  logic              lookup_hit;
  logic              fill_en;
  logic              hit_inc;
  logic              miss_inc;
  logic              unused_bytoff;

  assign req_tag       = imemaddr[31:IIDX_W+2];
  assign req_idx       = imemaddr[IIDX_W+1:2];
  assign fill_idx      = missaddr_q[IIDX_W-1:0];
  assign unused_bytoff = ^imemaddr[1:0];

  assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    missaddr_d = missaddr_q;
    ihit       = 1'b0;
    imemload   = '0;
    iREN       = 1'b0;
    iaddr      = '0;
    fill_en    = 1'b0;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;

    case (state_q)
      IDLE: begin
        if (imemREN) begin
          if (lookup_hit) begin
            ihit     = 1'b1;
            imemload = data_q[req_idx];
            hit_inc  = 1'b1;
          end else begin
            missaddr_d = imemaddr[31:2];
            miss_inc   = 1'b1;
            state_d    = FETCH;
          end
        end
      end
      FETCH: begin
        // The fill targets the latched address regardless of what the
        // datapath is presenting now.
        iREN  = 1'b1;
        iaddr = {missaddr_q, 2'b00};
        if (!iwait) begin
          fill_en = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      missaddr_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      missaddr_q <= missaddr_d;
      if (iflush) begin
        valid_q <= '0;
      end
      // Placed after the flush so a fill in the same cycle keeps its frame
      // valid; the fetched word is still coherent for a read-only cache.
      if (fill_en) begin
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  // NOTE: tag and data storage is not reset; the valid bits alone decide
  // whether a frame can hit, so clearing the payload would only cost reset
  // fan-out.
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= missaddr_q[29:IIDX_W];
      data_q[fill_idx] <= iload;
    end
  end

  sat_counter u_hit_cnt (
    .clk     (CLK),
    .rst_n   (nRST),
    .inc_i   (hit_inc),
    .count_o (hitcnt)
  );

  sat_counter u_miss_cnt (
    .clk     (CLK),
    .rst_n   (nRST),
    .inc_i   (miss_inc),
    .count_o (misscnt)
  );

endmodule

// File: tb/tb_icache.sv
// ----------------------------------------------------------------------------
// tb_icache
//   Directed scenarios with literal expectations, then a randomized phase.
//   A behavioural cache model (frames keyed by full word address) predicts
//   every output on every falling edge.
// ----------------------------------------------------------------------------
module tb_icache;
  import cpu_types_pkg::*;

  localparam int SETS = 16;

  logic  CLK = 1'b0;
  logic  nRST;
  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;
  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;
  logic  iflush;
  word_t hitcnt;
  word_t misscnt;

  icache #(.SETS(SETS)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .iflush   (iflush),
    .hitcnt   (hitcnt),
    .misscnt  (misscnt)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  // Backing memory: directed entries, otherwise a fixed address hash.
  word_t dmem [word_t];

  function automatic word_t mem_word(input word_t a);
    if (dmem.exists(a)) return dmem[a];
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Memory-controller responder: holds iwait high for wait_left cycles of
  // each request, then presents data with iwait low.
  int next_wait = 0;
  bit rand_wait = 1'b0;
  int wait_left = 0;

  initial begin
    iwait = 1'b1;
    iload = '0;
    forever begin
      tick();
      if (nRST && iREN) begin
        if (wait_left > 0) begin
          iwait = 1'b1;
          iload = $urandom;
          wait_left--;
        end else begin
          iwait = 1'b0;
          iload = mem_word(iaddr);
        end
      end else begin
        iwait     = 1'b1;
        iload     = $urandom;
        wait_left = rand_wait ? int'($urandom_range(0, 3)) : next_wait;
      end
    end
  end

  // Behavioural model: each frame remembers which word address it holds.
  bit          m_fetch;
  logic [29:0] m_miss;
  bit          m_valid [SETS];
  logic [29:0] m_addr  [SETS];
  word_t       m_data  [SETS];
  word_t       m_hits;
  word_t       m_misses;
  logic [29:0] c_w;
  int          c_idx;
  int          c_fi;
  bit          c_hit;

  initial begin
    forever begin
      @(negedge CLK);
      if (!nRST) begin
        m_fetch  = 1'b0;
        m_miss   = '0;
        m_hits   = '0;
        m_misses = '0;
        foreach (m_valid[i]) m_valid[i] = 1'b0;
        check("model_rst_ihit", 32'(ihit), 0);
        check("model_rst_imemload", imemload, 0);
        check("model_rst_iREN", 32'(iREN), 0);
        check("model_rst_iaddr", iaddr, 0);
        check("model_rst_hitcnt", hitcnt, 0);
        check("model_rst_misscnt", misscnt, 0);
      end else begin
        c_w   = imemaddr[31:2];
        c_idx = int'(c_w) % SETS;
        c_hit = 1'b0;
        if (m_fetch) begin
          check("model_iREN", 32'(iREN), 1);
          check("model_iaddr", iaddr, {m_miss, 2'b00});
          check("model_ihit", 32'(ihit), 0);
          check("model_imemload", imemload, 0);
        end else begin
          c_hit = imemREN && m_valid[c_idx] && (m_addr[c_idx] == c_w);
          check("model_iREN", 32'(iREN), 0);
          check("model_ihit", 32'(ihit), 32'(c_hit));
          check("model_imemload", imemload, c_hit ? m_data[c_idx] : 32'h0);
        end
        check("model_hitcnt", hitcnt, m_hits);
        check("model_misscnt", misscnt, m_misses);

        // Advance the model across the coming rising edge.
        if (iflush) foreach (m_valid[i]) m_valid[i] = 1'b0;
        if (m_fetch) begin
          if (!iwait) begin
            c_fi          = int'(m_miss) % SETS;
            m_valid[c_fi] = 1'b1;
            m_addr[c_fi]  = m_miss;
            m_data[c_fi]  = iload;
            m_fetch       = 1'b0;
          end
        end else if (imemREN) begin
          if (c_hit) begin
            if (m_hits != 32'hFFFF_FFFF) m_hits++;
          end else begin
            if (m_misses != 32'hFFFF_FFFF) m_misses++;
            m_fetch = 1'b1;
            m_miss  = c_w;
          end
        end
      end
    end
  end

  // Waits (bounded) for a hit; counts iREN cycles on the way. Returns at the
  // falling edge where ihit is high.
  task automatic wait_hit(output int ren_cyc, output word_t first_ia);
    bit got;
    got      = 1'b0;
    ren_cyc  = 0;
    first_ia = '0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge CLK);
      if (ihit) begin
        got = 1'b1;
      end else begin
        if (iREN) begin
          if (ren_cyc == 0) first_ia = iaddr;
          ren_cyc++;
        end
        tick();
      end
    end
    check("hit_timeout", 32'(got), 1);
  endtask

  // Call from a falling edge.
  task automatic run_to_hit(input word_t a, input int w, output int ren_cyc, output word_t first_ia);
    next_wait = w;
    tick();
    imemREN  = 1'b1;
    imemaddr = a;
    wait_hit(ren_cyc, first_ia);
  endtask

  // Call from a falling edge; returns at the falling edge of the first FETCH cycle.
  task automatic start_miss(input word_t a, input int w);
    bit seen;
    seen      = 1'b0;
    next_wait = w;
    tick();
    imemREN  = 1'b1;
    imemaddr = a;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      if (iREN) seen = 1'b1;
      else tick();
    end
    check("fetch_start_timeout", 32'(seen), 1);
  endtask

  int    ren;
  word_t ia;
  bit    done;
  word_t wd;

  initial begin
    nRST     = 1'b0;
    imemREN  = 1'b0;
    imemaddr = '0;
    iflush   = 1'b0;
    #3;
    check("rst_iREN", 32'(iREN), 0);
    check("rst_iaddr", iaddr, 0);
    check("rst_ihit", 32'(ihit), 0);
    check("rst_imemload", imemload, 0);
    check("rst_hitcnt", hitcnt, 0);
    check("rst_misscnt", misscnt, 0);
    dmem[32'h40] = 32'h2001_0005;
    repeat (2) tick();
    nRST = 1'b1;
    @(negedge CLK);

    // Cold miss: four iREN cycles at 0x40, then the hit.
    run_to_hit(32'h40, 3, ren, ia);
    check("cold_ren_cycles", 32'(ren), 4);
    check("cold_iaddr", ia, 32'h40);
    check("cold_data", imemload, 32'h2001_0005);
    check("cold_misscnt", misscnt, 1);
    check("cold_hitcnt_pre", hitcnt, 0);

    // Repeat hits on the same address.
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge CLK);
      check("rep_ihit", 32'(ihit), 1);
      check("rep_iREN", 32'(iREN), 0);
      if (i == 0) check("rep_hitcnt_first", hitcnt, 1);
    end
    tick();
    imemREN = 1'b0;
    @(negedge CLK);
    check("rep_hitcnt", hitcnt, 6);

    // Conflict eviction: 0x40 and 0x80 share frame 0.
    run_to_hit(32'h80, 1, ren, ia);
    check("conf80_missed", 32'(ren > 0), 1);
    check("conf80_iaddr", ia, 32'h80);
    check("conf80_data", imemload, mem_word(32'h80));
    run_to_hit(32'h40, 2, ren, ia);
    check("conf40_missed", 32'(ren > 0), 1);
    check("conf40_data", imemload, 32'h2001_0005);
    check("conf_misscnt", misscnt, 3);

    // Address change during the fill.
    start_miss(32'h100, 3);
    next_wait = 1;
    tick();
    imemaddr = 32'h104;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge CLK);
      if (!iREN) done = 1'b1;
      else begin
        check("mf_iaddr_stable", iaddr, 32'h100);
        tick();
      end
    end
    check("mf_fill_done", 32'(done), 1);
    check("mf_idle_miss", 32'(ihit), 0);
    tick();
    @(negedge CLK);
    check("mf_refetch_iREN", 32'(iREN), 1);
    check("mf_refetch_iaddr", iaddr, 32'h104);
    wait_hit(ren, ia);
    check("mf_104_data", imemload, mem_word(32'h104));
    run_to_hit(32'h100, 0, ren, ia);
    check("mf_100_filled", 32'(ren), 0);
    check("mf_100_data", imemload, mem_word(32'h100));

    // Flush in IDLE: refetch misses, counters survive.
    run_to_hit(32'h40, 0, ren, ia);
    check("fl_fill_missed", 32'(ren > 0), 1);
    tick();
    imemREN = 1'b0;
    iflush  = 1'b1;
    tick();
    iflush = 1'b0;
    @(negedge CLK);
    run_to_hit(32'h40, 1, ren, ia);
    check("fl_refetch_missed", 32'(ren > 0), 1);
    check("fl_misscnt", misscnt, 7);
    check("fl_hitcnt", hitcnt, 11);

    // Flush on the fill edge: the fill wins, other frames are cleared.
    start_miss(32'h200, 1);
    tick();
    iflush = 1'b1;
    @(negedge CLK);
    check("ff_fill_cycle_iREN", 32'(iREN), 1);
    check("ff_fill_cycle_iwait", 32'(iwait), 0);
    tick();
    iflush = 1'b0;
    @(negedge CLK);
    check("ff_hit", 32'(ihit), 1);
    check("ff_data", imemload, mem_word(32'h200));
    run_to_hit(32'h104, 0, ren, ia);
    check("ff_other_flushed", 32'(ren > 0), 1);

    // Reset in the middle of a fill.
    start_miss(32'h300, 5);
    tick();
    nRST = 1'b0;
    #1;
    check("rstmid_iREN", 32'(iREN), 0);
    check("rstmid_ihit", 32'(ihit), 0);
    check("rstmid_hitcnt", hitcnt, 0);
    check("rstmid_misscnt", misscnt, 0);
    imemREN = 1'b0;
    tick();
    tick();
    nRST = 1'b1;
    @(negedge CLK);
    check("rel_hitcnt", hitcnt, 0);
    check("rel_misscnt", misscnt, 0);
    run_to_hit(32'h40, 0, ren, ia);
    check("rel_missed", 32'(ren > 0), 1);
    check("rel_misscnt_after", misscnt, 1);
    check("rel_data", imemload, 32'h2001_0005);

    // Randomized traffic against the model.
    rand_wait = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      imemREN = ($urandom_range(0, 7) != 0);
      wd      = word_t'($urandom_range(0, 47));
      if ($urandom_range(0, 3) == 0) wd = wd + 32'h0400_0000;
      imemaddr = (wd << 2) | word_t'($urandom_range(0, 3));
      iflush   = ($urandom_range(0, 39) == 0);
    end
    tick();
    imemREN = 1'b0;
    iflush  = 1'b0;
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
